// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one memory port between instruction fetch and
// the load/store unit. One transaction is outstanding at a time, and the
// response is steered back to whichever side issued it. A fetch can be
// killed (branch redirect) so its stale response is dropped. Load/store
// normally has priority over fetch.
// Optional feature: define ARB_STARVE_EN to promote fetch after STARVE_MAX
// lost issue slots.
module imem_dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rstn,
  // instruction fetch
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_kill,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  // load/store
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  // memory bus
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  state_t state, state_next;
  logic   killed, killed_next;
  logic   issue_slot;
  logic   pick_if, pick_ls;
  logic   promote;

`ifdef ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt, starve_cnt_next;

  // Fetch wins outright once it has lost STARVE_MAX issue slots in a row.
  assign promote = (starve_cnt == CW'(STARVE_MAX));

  // Starvation counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) starve_cnt <= '0;
    else       starve_cnt <= starve_cnt_next;
  end

  // Count issue slots where fetch wanted the bus but load/store took it.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (if_gnt)
      starve_cnt_next = '0;
    else if (issue_slot && if_req && !pick_if && !promote)
      starve_cnt_next = starve_cnt + 1'b1;
  end
`else
  assign promote = 1'b0;
`endif

  // State and kill flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      killed <= 1'b0;
    end else begin
      state  <= state_next;
      killed <= killed_next;
    end
  end

  // Arbitration, request steering, response routing and next state.
  always_comb begin
    // An issue is possible when idle, or when the outstanding transaction
    // completes this cycle (back-to-back). Held off while in reset so every
    // output is quiet.
    issue_slot  = rstn && ((state == IDLE) || mem_rvalid);
    pick_ls     = issue_slot && ls_req && !promote;
    pick_if     = issue_slot && if_req && (!ls_req || promote);

    mem_req     = pick_ls || pick_if;
    mem_we      = 1'b0;
    mem_be      = '0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (pick_ls) begin
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (pick_if) begin
      mem_be    = '1;
      mem_addr  = if_addr;
    end

    ls_gnt      = pick_ls && mem_gnt;
    if_gnt      = pick_if && mem_gnt;

    // A kill either earlier in the transaction or in the response cycle
    // itself drops the fetch response.
    if_rvalid   = (state == BUSY_IF) && mem_rvalid && !killed && !if_kill;
    ls_rvalid   = (state == BUSY_LS) && mem_rvalid;
    if_rdata    = if_rvalid ? mem_rdata : '0;
    ls_rdata    = ls_rvalid ? mem_rdata : '0;

    state_next  = state;
    if (ls_gnt)
      state_next = BUSY_LS;
    else if (if_gnt)
      state_next = BUSY_IF;
    else if (state != IDLE && mem_rvalid)
      state_next = IDLE;

    // The kill flag belongs to the current fetch only; it is dropped as soon
    // as that fetch completes, even if another fetch follows immediately.
    killed_next = 1'b0;
    if (state == BUSY_IF && !mem_rvalid)
      killed_next = killed || if_kill;
  end

endmodule
